awmc_prog_ctrl: RTL and testbench

//  Programmable washing-machine sequencer; successor to the fixed-sequence controller.

---
 rtl/awmc_prog_ctrl_if.sv | 29 ++
 rtl/awmc_prog_ctrl.sv | 179 +++++++++++++++++
 tb/tb_awmc_prog_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/awmc_prog_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : awmc_prog_ctrl_if
// Description : Front-panel / driver bundle of the programmable washer sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface awmc_prog_ctrl_if;
    logic       start;
    logic       pause;
    logic       lid;
    logic       abort;
    logic [1:0] mode;
    logic [2:0] stage;
    logic       done;
    logic       paused;
    logic       lid_fault;
    logic [2:0] rinse_idx;

    modport master (
        output start, pause, lid, abort, mode,
        input  stage, done, paused, lid_fault, rinse_idx
    );

    modport slave (
        input  start, pause, lid, abort, mode,
        output stage, done, paused, lid_fault, rinse_idx
    );
endinterface
`default_nettype wire

// File: rtl/awmc_prog_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : awmc_prog_ctrl
// Description : Programmable FILL/WASH/RINSE/SPIN sequencer with holds and abort.
// Revision    : 1.0 - initial release
// ============================================================================
module awmc_prog_ctrl #(
    parameter int TW      = 8,
    parameter int T_FILL  = 4,
    parameter int T_WASH  = 8,
    parameter int T_RINSE = 4,
    parameter int N_RINSE = 2,
    parameter int T_SPIN  = 6,
    parameter int T_DRAIN = 3
) (
    input  logic           clk,
    input  logic           reset,
    awmc_prog_ctrl_if.slave bus
);
    localparam logic [1:0] C_MODE_QUICK = 2'd1;
    localparam logic [1:0] C_MODE_HEAVY = 2'd2;
    localparam logic [1:0] C_MODE_RINSE = 2'd3;

    localparam int C_FILL_Q  = ((T_FILL  >> 1) == 0) ? 1 : (T_FILL  >> 1);
    localparam int C_WASH_Q  = ((T_WASH  >> 1) == 0) ? 1 : (T_WASH  >> 1);
    localparam int C_RINSE_Q = ((T_RINSE >> 1) == 0) ? 1 : (T_RINSE >> 1);
    localparam int C_SPIN_Q  = ((T_SPIN  >> 1) == 0) ? 1 : (T_SPIN  >> 1);
    localparam int C_WASH_H  = 2 * T_WASH;

    localparam logic [2:0] C_RLAST_NORM  = 3'(N_RINSE - 1);
    localparam logic [2:0] C_RLAST_HEAVY = 3'(N_RINSE);

    if (T_FILL < 1 || T_WASH < 1 || T_RINSE < 1 || T_SPIN < 1 || T_DRAIN < 1) begin : g_chk_min
        $error("awmc_prog_ctrl: every duration must be at least 1");
    end
    if (N_RINSE < 1 || N_RINSE > 7) begin : g_chk_rinse
        $error("awmc_prog_ctrl: N_RINSE must be in 1..7");
    end
    if (T_FILL >= (1 << TW) || C_WASH_H >= (1 << TW) || T_RINSE >= (1 << TW) ||
        T_SPIN >= (1 << TW) || T_DRAIN >= (1 << TW)) begin : g_chk_width
        $error("awmc_prog_ctrl: a duration does not fit the TW-bit timer");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WASH  = 3'd2,
        ST_RINSE = 3'd3,
        ST_SPIN  = 3'd4,
        ST_DRAIN = 3'd5,
        ST_DONE  = 3'd6
    } stage_t;

    stage_t          r_stage;
    logic [TW-1:0]   r_timer;
    logic [2:0]      r_rinse_idx;
    logic [1:0]      r_mode;
    logic            r_done;
    logic            r_paused;
    logic            r_lid_fault;
    logic            r_start_lo;   // start was sampled low; cleared by reset so a held start cannot launch

    logic [TW-1:0]   w_dur;
    logic            w_timer_end;
    logic            w_start_edge;
    logic            w_hold;
    logic [2:0]      w_rinse_last;

    assign w_start_edge = bus.start & r_start_lo;
    assign w_hold       = bus.pause | ~bus.lid;
    assign w_timer_end  = (r_timer == (w_dur - TW'(1)));

    always_comb begin
        w_dur = TW'(1);
        case (r_stage)
            ST_FILL:  w_dur = (r_mode == C_MODE_QUICK) ? TW'(C_FILL_Q) : TW'(T_FILL);
            ST_WASH:  w_dur = (r_mode == C_MODE_QUICK) ? TW'(C_WASH_Q) :
                              (r_mode == C_MODE_HEAVY) ? TW'(C_WASH_H) : TW'(T_WASH);
            ST_RINSE: w_dur = (r_mode == C_MODE_QUICK) ? TW'(C_RINSE_Q) : TW'(T_RINSE);
            ST_SPIN:  w_dur = (r_mode == C_MODE_QUICK) ? TW'(C_SPIN_Q) : TW'(T_SPIN);
            ST_DRAIN: w_dur = TW'(T_DRAIN);
            default:  w_dur = TW'(1);
        endcase
    end

    always_comb begin
        w_rinse_last = C_RLAST_NORM;
        if (r_mode == C_MODE_QUICK) begin
            w_rinse_last = 3'd0;
        end else if (r_mode == C_MODE_HEAVY) begin
            w_rinse_last = C_RLAST_HEAVY;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stage     <= ST_IDLE;
            r_timer     <= '0;
            r_rinse_idx <= '0;
            r_mode      <= '0;
            r_done      <= 1'b0;
            r_paused    <= 1'b0;
            r_lid_fault <= 1'b0;
            r_start_lo  <= 1'b0;
        end else begin
            r_start_lo  <= ~bus.start;
            r_done      <= 1'b0;
            r_paused    <= 1'b0;
            r_lid_fault <= 1'b0;
            case (r_stage)
                ST_IDLE: begin
                    if (w_start_edge && bus.lid && !bus.abort) begin
                        r_mode      <= bus.mode;
                        r_timer     <= '0;
                        r_rinse_idx <= '0;
                        r_stage     <= (bus.mode == C_MODE_RINSE) ? ST_RINSE : ST_FILL;
                    end
                end
                ST_FILL, ST_WASH, ST_RINSE, ST_SPIN: begin
                    // abort outranks holds and stage completion
                    if (bus.abort) begin
                        r_stage     <= ST_DRAIN;
                        r_timer     <= '0;
                        r_rinse_idx <= '0;
                    end else if (w_hold) begin
                        r_paused    <= bus.pause;
                        r_lid_fault <= ~bus.lid;
                    end else if (w_timer_end) begin
                        r_timer <= '0;
                        if (r_stage == ST_FILL) begin
                            r_stage <= ST_WASH;
                        end else if (r_stage == ST_WASH) begin
                            r_stage <= ST_RINSE;
                        end else if (r_stage == ST_RINSE) begin
                            if (r_rinse_idx == w_rinse_last) begin
                                r_stage     <= ST_SPIN;
                                r_rinse_idx <= '0;
                            end else begin
                                r_rinse_idx <= r_rinse_idx + 3'd1;
                            end
                        end else begin
                            r_stage <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (w_timer_end) begin
                        r_stage <= ST_IDLE;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_DONE: begin
                    if (!bus.start) begin
                        r_stage <= ST_IDLE;
                    end else begin
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_stage <= ST_IDLE;
                    r_timer <= '0;
                end
            endcase
        end
    end

    assign bus.stage     = r_stage;
    assign bus.done      = r_done;
    assign bus.paused    = r_paused;
    assign bus.lid_fault = r_lid_fault;
    assign bus.rinse_idx = r_rinse_idx;

endmodule
`default_nettype wire

// File: tb/tb_awmc_prog_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_awmc_prog_ctrl
// Description : Directed, table-driven bench for the programmable washer sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_awmc_prog_ctrl;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    awmc_prog_ctrl_if bus ();

    awmc_prog_ctrl #(
        .TW(8), .T_FILL(4), .T_WASH(8), .T_RINSE(4),
        .N_RINSE(2), .T_SPIN(6), .T_DRAIN(3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pause driven while p_lo <= c < p_hi, lid opened while l_lo <= c < l_hi (c = cycles since launch)
    typedef struct {
        logic [1:0] mode;
        int p_lo; int p_hi; int l_lo; int l_hi;
        int fill; int wash; int rinse; int spin; int done_at;
        int max_ri; int n_paused; int n_lidf;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic launch(input logic [1:0] m);
        bus.start = 1'b0;
        bus.mode  = m;
        tick();
        bus.start = 1'b1;
        tick();
    endtask

    initial begin
        int fill_n, wash_n, rinse_n, spin_n, cyc, max_ri, np, nl, ri_bad, nd;
        logic seen_done;

        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{2'd0, -1, -1, -1, -1, 4,  8,  8,  6, 26, 1, 0, 0};
        vecs[1] = '{2'd1, -1, -1, -1, -1, 2,  4,  2,  3, 11, 0, 0, 0};
        vecs[2] = '{2'd2, -1, -1, -1, -1, 4, 16, 12,  6, 38, 2, 0, 0};
        vecs[3] = '{2'd3, -1, -1, -1, -1, 0,  0,  8,  6, 14, 1, 0, 0};
        vecs[4] = '{2'd0,  7, 12, -1, -1, 4, 13,  8,  6, 31, 1, 5, 0};
        vecs[5] = '{2'd0, 23, 27, 21, 25, 4,  8,  8, 12, 32, 1, 4, 4};
        vecs[6] = '{2'd1,  0,  1, -1, -1, 3,  4,  2,  3, 12, 0, 1, 0};

        reset     = 1'b0;
        bus.start = 1'b0;
        bus.pause = 1'b0;
        bus.lid   = 1'b1;
        bus.abort = 1'b0;
        bus.mode  = 2'd0;
        tick();
        tick();
        check("reset stage", int'(bus.stage), 0);
        check("reset done", int'(bus.done), 0);
        check("reset paused", int'(bus.paused), 0);
        check("reset lid_fault", int'(bus.lid_fault), 0);
        check("reset rinse_idx", int'(bus.rinse_idx), 0);
        #2 reset = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            fill_n = 0; wash_n = 0; rinse_n = 0; spin_n = 0;
            max_ri = 0; np = 0; nl = 0; ri_bad = 0; cyc = 0;
            launch(vecs[i].mode);
            while (!bus.done && cyc < 100) begin
                case (bus.stage)
                    3'd1: fill_n++;
                    3'd2: wash_n++;
                    3'd3: rinse_n++;
                    3'd4: spin_n++;
                    default: ;
                endcase
                if (int'(bus.rinse_idx) > max_ri) max_ri = int'(bus.rinse_idx);
                if (bus.stage != 3'd3 && bus.rinse_idx != 3'd0) ri_bad++;
                if (bus.paused) np++;
                if (bus.lid_fault) nl++;
                bus.pause = (cyc >= vecs[i].p_lo && cyc < vecs[i].p_hi);
                bus.lid   = !(cyc >= vecs[i].l_lo && cyc < vecs[i].l_hi);
                tick();
                cyc++;
            end
            bus.pause = 1'b0;
            bus.lid   = 1'b1;
            check($sformatf("row%0d fill cycles", i), fill_n, vecs[i].fill);
            check($sformatf("row%0d wash cycles", i), wash_n, vecs[i].wash);
            check($sformatf("row%0d rinse cycles", i), rinse_n, vecs[i].rinse);
            check($sformatf("row%0d spin cycles", i), spin_n, vecs[i].spin);
            check($sformatf("row%0d done cycle", i), cyc, vecs[i].done_at);
            check($sformatf("row%0d max rinse_idx", i), max_ri, vecs[i].max_ri);
            check($sformatf("row%0d paused cycles", i), np, vecs[i].n_paused);
            check($sformatf("row%0d lid_fault cycles", i), nl, vecs[i].n_lidf);
            check($sformatf("row%0d rinse_idx outside rinse", i), ri_bad, 0);
            check($sformatf("row%0d done stage", i), int'(bus.stage), 6);
            tick();
            check($sformatf("row%0d done held", i), int'(bus.done), 1);
            bus.start = 1'b0;
            tick();
            check($sformatf("row%0d idle after done", i), int'(bus.stage), 0);
            check($sformatf("row%0d done cleared", i), int'(bus.done), 0);
        end

        // start edge with lid open, then abort-blocked edge: neither launches
        bus.lid = 1'b0;
        launch(2'd0);
        check("lid open launch ignored", int'(bus.stage), 0);
        bus.lid = 1'b1;
        tick();
        tick();
        check("no launch without fresh edge", int'(bus.stage), 0);
        bus.abort = 1'b1;
        launch(2'd0);
        check("abort in idle blocks launch", int'(bus.stage), 0);
        bus.abort = 1'b0;
        tick();

        // abort with pause on the final rinse pass end
        launch(2'd0);
        for (int k = 0; k < 19; k++) tick();
        check("pre-abort stage", int'(bus.stage), 3);
        check("pre-abort rinse_idx", int'(bus.rinse_idx), 1);
        bus.abort = 1'b1;
        bus.pause = 1'b1;
        tick();
        check("abort enters drain", int'(bus.stage), 5);
        check("abort clears rinse_idx", int'(bus.rinse_idx), 0);
        check("abort paused flag", int'(bus.paused), 0);
        bus.abort = 1'b0;
        bus.lid   = 1'b0;
        nd = 0;
        seen_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (bus.stage == 3'd5) nd++;
            if (bus.done) seen_done = 1'b1;
            if (bus.stage == 3'd0) break;
            tick();
        end
        check("drain cycles", nd, 3);
        check("idle after drain", int'(bus.stage), 0);
        check("done never after abort", int'(seen_done), 0);
        bus.pause = 1'b0;
        bus.lid   = 1'b1;
        tick();

        // async reset mid-WASH with start held high
        launch(2'd0);
        for (int k = 0; k < 5; k++) tick();
        bus.pause = 1'b1;
        tick();
        check("pre-reset stage", int'(bus.stage), 2);
        check("pre-reset paused", int'(bus.paused), 1);
        #2 reset = 1'b0;
        #1;
        check("async reset stage", int'(bus.stage), 0);
        check("async reset paused", int'(bus.paused), 0);
        check("async reset done", int'(bus.done), 0);
        check("async reset lid_fault", int'(bus.lid_fault), 0);
        check("async reset rinse_idx", int'(bus.rinse_idx), 0);
        #1 reset = 1'b1;
        bus.pause = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("no relaunch after reset", int'(bus.stage), 0);
        launch(2'd3);
        check("fresh edge relaunches", int'(bus.stage), 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
